// File: rtl/ranger_ai.sv
// Ranger enemy AI: picks patrol, chase/retreat or fire each movement decision and emits one-hot move / fire pulses.
// Optional screen-bounds move suppression is enabled by defining RANGER_AI_BOUNDS_EN.
module ranger_ai #(
    parameter int MOVE_DIV        = 4,
    parameter int SIGHT_RANGE     = 200,
    parameter int ATTACK_RANGE    = 120,
    parameter int FLEE_RANGE      = 40,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int PATROL_STEPS    = 16
`ifdef RANGER_AI_BOUNDS_EN
    ,
    parameter int H_MIN           = 8,
    parameter int H_MAX           = 631,
    parameter int V_MIN           = 8,
    parameter int V_MAX           = 471
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic [19:0] player_pos,
    input  logic [19:0] ranger_pos,
    output logic [3:0]  move_dir,
    output logic        fire,
    output logic [2:0]  ai_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PATROL   = 3'd1,
        S_APPROACH = 3'd2,
        S_RETREAT  = 3'd3,
        S_ATTACK   = 3'd4,
        S_COOLDOWN = 3'd5
    } state_t;

    localparam int STEP_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int COOL_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam int PCNT_W = (PATROL_STEPS > 1) ? $clog2(PATROL_STEPS) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(MOVE_DIV - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST   = PCNT_W'(PATROL_STEPS - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD   = COOL_W'(COOLDOWN_FRAMES);
    localparam logic [10:0]       SIGHT_LIM   = 11'(SIGHT_RANGE);
    localparam logic [10:0]       ATTACK_LIM  = 11'(ATTACK_RANGE);
    localparam logic [10:0]       FLEE_LIM    = 11'(FLEE_RANGE);

    localparam logic [3:0] MOVE_UP    = 4'b1000;
    localparam logic [3:0] MOVE_DOWN  = 4'b0100;
    localparam logic [3:0] MOVE_LEFT  = 4'b0010;
    localparam logic [3:0] MOVE_RIGHT = 4'b0001;
    localparam logic [3:0] MOVE_NONE  = 4'b0000;

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step_cnt, step_nxt;
    logic [COOL_W-1:0]   cooldown_cnt, cool_nxt;
    logic [PCNT_W-1:0]   patrol_cnt, pcnt_nxt;
    logic                patrol_dir, pdir_nxt;
    logic [3:0]          move_nxt;
    logic                fire_nxt;

    logic [9:0]  ph, pv, rh, rv;
    logic [9:0]  dh_c, dv_c;
    logic [9:0]  dh_q, dv_q;
    logic [10:0] dist_q;
    logic        ph_gt_q, pv_gt_q;

    assign ph = player_pos[19:10];
    assign pv = player_pos[9:0];
    assign rh = ranger_pos[19:10];
    assign rv = ranger_pos[9:0];

    assign dh_c = (ph > rh) ? (ph - rh) : (rh - ph);
    assign dv_c = (pv > rv) ? (pv - rv) : (rv - pv);

    // Distance pipeline stage; the decision logic only ever sees these registered values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dh_q    <= '0;
            dv_q    <= '0;
            dist_q  <= '0;
            ph_gt_q <= 1'b0;
            pv_gt_q <= 1'b0;
        end else begin
            dh_q    <= dh_c;
            dv_q    <= dv_c;
            dist_q  <= {1'b0, dh_c} + {1'b0, dv_c};
            ph_gt_q <= ph > rh;
            pv_gt_q <= pv > rv;
        end
    end

    logic [3:0] patrol_move, chase_move, flee_move;
    logic       patrol_blk, chase_blk, flee_blk;

    always_comb begin
        patrol_move = patrol_dir ? MOVE_LEFT : MOVE_RIGHT;
        if (dh_q >= dv_q)
            chase_move = ph_gt_q ? MOVE_RIGHT : MOVE_LEFT;
        else
            chase_move = pv_gt_q ? MOVE_DOWN : MOVE_UP;
        if (dh_q == 10'd0 && dv_q == 10'd0)
            flee_move = MOVE_UP;
        else if (dh_q >= dv_q)
            flee_move = ph_gt_q ? MOVE_LEFT : MOVE_RIGHT;
        else
            flee_move = pv_gt_q ? MOVE_UP : MOVE_DOWN;
    end

`ifdef RANGER_AI_BOUNDS_EN
    logic [9:0] rh_q, rv_q;

    // Position aligned with the distance stage so bound checks match the decision inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rh_q <= '0;
            rv_q <= '0;
        end else begin
            rh_q <= rh;
            rv_q <= rv;
        end
    end

    function automatic logic is_blocked(input logic [3:0] m, input logic [9:0] h, input logic [9:0] v);
        logic res;
        res = 1'b0;
        case (m)
            MOVE_RIGHT: res = ({1'b0, h} + 11'd5) > 11'(H_MAX);
            MOVE_LEFT:  res = {1'b0, h} < 11'(H_MIN + 5);
            MOVE_DOWN:  res = ({1'b0, v} + 11'd5) > 11'(V_MAX);
            MOVE_UP:    res = {1'b0, v} < 11'(V_MIN + 5);
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

    always_comb begin
        patrol_blk = is_blocked(patrol_move, rh_q, rv_q);
        chase_blk  = is_blocked(chase_move, rh_q, rv_q);
        flee_blk   = is_blocked(flee_move, rh_q, rv_q);
    end
`else
    always_comb begin
        patrol_blk = 1'b0;
        chase_blk  = 1'b0;
        flee_blk   = 1'b0;
    end
`endif

    // Next-state, counter and pulse logic; enable low overrides everything.
    always_comb begin
        state_nxt = state;
        step_nxt  = step_cnt;
        cool_nxt  = cooldown_cnt;
        pcnt_nxt  = patrol_cnt;
        pdir_nxt  = patrol_dir;
        move_nxt  = MOVE_NONE;
        fire_nxt  = 1'b0;

        if (!enable) begin
            state_nxt = S_IDLE;
            step_nxt  = '0;
            cool_nxt  = '0;
            pcnt_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_PATROL;
                    step_nxt  = '0;
                end
                S_PATROL, S_APPROACH, S_RETREAT: begin
                    if (frame_tick) begin
                        if (step_cnt != STEP_LAST) begin
                            step_nxt = step_cnt + STEP_W'(1);
                        end else begin
                            step_nxt = '0;
                            if (dist_q > SIGHT_LIM) begin
                                state_nxt = S_PATROL;
                                if (patrol_blk) begin
                                    pdir_nxt = ~patrol_dir;
                                    pcnt_nxt = '0;
                                end else begin
                                    move_nxt = patrol_move;
                                    if (patrol_cnt == PCNT_LAST) begin
                                        pdir_nxt = ~patrol_dir;
                                        pcnt_nxt = '0;
                                    end else begin
                                        pcnt_nxt = patrol_cnt + PCNT_W'(1);
                                    end
                                end
                            end else if (dist_q > ATTACK_LIM) begin
                                state_nxt = S_APPROACH;
                                move_nxt  = chase_blk ? MOVE_NONE : chase_move;
                            end else if (dist_q < FLEE_LIM) begin
                                state_nxt = S_RETREAT;
                                move_nxt  = flee_blk ? MOVE_NONE : flee_move;
                            end else begin
                                state_nxt = S_ATTACK;
                                fire_nxt  = 1'b1;
                            end
                        end
                    end
                end
                S_ATTACK: begin
                    state_nxt = S_COOLDOWN;
                    step_nxt  = '0;
                    cool_nxt  = COOL_LOAD;
                end
                S_COOLDOWN: begin
                    step_nxt = '0;
                    if (cooldown_cnt == '0) begin
                        state_nxt = S_PATROL;
                    end else if (frame_tick) begin
                        cool_nxt = cooldown_cnt - COOL_W'(1);
                        if (cooldown_cnt == COOL_W'(1))
                            state_nxt = S_PATROL;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    step_nxt  = '0;
                    cool_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            step_cnt     <= '0;
            cooldown_cnt <= '0;
            patrol_cnt   <= '0;
            patrol_dir   <= 1'b0;
            move_dir     <= MOVE_NONE;
            fire         <= 1'b0;
        end else begin
            state        <= state_nxt;
            step_cnt     <= step_nxt;
            cooldown_cnt <= cool_nxt;
            patrol_cnt   <= pcnt_nxt;
            patrol_dir   <= pdir_nxt;
            move_dir     <= move_nxt;
            fire         <= fire_nxt;
        end
    end

    assign ai_state = state;

endmodule

// File: doc/ranger_ai.md
Name: ranger_ai

Overview:
- Upstream command generator for one ranger enemy.
- Each frame it compares the ranger's current position with the player's position and decides on one of three actions: patrol, chase/retreat, or fire.
- It issues one-hot single-cycle movement commands to the ranger movement block, whose 20-bit {hpos,vpos} position output is fed back here.
- It also raises a fire pulse for the projectile spawner.

Parameters:
- MOVE_DIV, 4, frame_ticks per movement decision (>=1).
- SIGHT_RANGE, 200, Manhattan distance (pixels) beyond which the ranger patrols.
- ATTACK_RANGE, 120, upper bound of the firing band (inclusive).
- FLEE_RANGE, 40, lower bound of the firing band (inclusive); closer than this the ranger retreats.
- COOLDOWN_FRAMES, 30, frame_ticks spent stationary after firing.
- PATROL_STEPS, 16, steps in one patrol direction before reversing.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  AI active (level).
- frame_tick  input  1  one-cycle pulse per video frame.
- player_pos  input  20  {h[19:10], v[9:0]} unsigned pixels.
- ranger_pos  input  20  {h[19:10], v[9:0]} from the ranger movement block.
- move_dir  output  4  one-hot command: 1000 up, 0100 down, 0010 left, 0001 right, 0000 none.
- fire  output  1  one-cycle fire pulse.
- ai_state  output  3  0 IDLE, 1 PATROL, 2 APPROACH, 3 RETREAT, 4 ATTACK, 5 COOLDOWN.

Behaviour:
- Reset (async, rst_n=0):
  - move_dir=0000, fire=0, ai_state=IDLE.
  - step_cnt=0, cooldown_cnt=0, patrol_cnt=0, patrol_dir=right.
- Distance stage (registered every cycle):
  - dh=|ph-rh|, dv=|pv-rv|, each 10-bit.
  - dist=dh+dv, 11-bit, no overflow.
  - Decisions use these registered values, so their inputs are 1 cycle old.
- step_cnt:
  - Increments on frame_tick.
  - On a frame_tick where step_cnt==MOVE_DIV-1, the cycle is a "decision tick" and step_cnt wraps to 0.
  - Held at 0 in IDLE, ATTACK and COOLDOWN.
- move_dir and fire are registered outputs.
  - Each is high for exactly the one cycle after the decision tick, and 0000/0 otherwise.
- IDLE:
  - Moves to PATROL on the first cycle enable=1.
  - enable=0 in any state forces IDLE on the next cycle, clears all counters and suppresses any pending pulse.
- Decision tick, from PATROL/APPROACH/RETREAT, priority in order:
  1. dist>SIGHT_RANGE → PATROL. Emit patrol_dir (0010/0001). Increment patrol_cnt; when it reaches PATROL_STEPS, flip patrol_dir and clear patrol_cnt.
  2. dist>ATTACK_RANGE → APPROACH. Move toward the player along the larger axis; dh==dv selects horizontal. Toward means right if ph>rh, down if pv>rv.
  3. dist<FLEE_RANGE → RETREAT. Move away from the player along the larger axis (tie horizontal). dh==0 and dv==0 → move up.
  4. Otherwise (FLEE_RANGE<=dist<=ATTACK_RANGE) → ATTACK. No move.
- ATTACK:
  - Lasts one cycle with fire=1.
  - Then COOLDOWN, with cooldown_cnt loaded to COOLDOWN_FRAMES.
- COOLDOWN:
  - cooldown_cnt decrements on each frame_tick.
  - When it reaches 0 → PATROL. The next decision re-evaluates from step_cnt=0.
  - move_dir=0000 throughout.
- Patrol state is preserved when leaving PATROL: patrol_cnt and patrol_dir are not cleared on APPROACH/RETREAT.
- At most one bit of move_dir is ever set; move_dir and fire are never both non-zero.

Optional Feature:
- Macro: RANGER_AI_BOUNDS_EN.
- Defined: four extra parameters H_MIN=8, H_MAX=631, V_MIN=8, V_MAX=471.
  - A move whose 5-pixel step would place the ranger outside [min,max] is suppressed (move_dir=0000).
  - In PATROL, a blocked move also flips patrol_dir and clears patrol_cnt immediately.
- Undefined: no bounds check; logic and parameters absent.

Test Plan:
- Reset: rst_n=0 mid-COOLDOWN → next cycle ai_state=0, move_dir=0000, fire=0; counters read 0 after release.
- Patrol: ranger (263,170), player (600,170), dist=337, enable=1, frame_ticks → move_dir=0001 pulse after tick 4, 8, …; after 16 pulses it becomes 0010.
- Approach: player (400,180) (dh=137, dv=10, dist=147) → ai_state=2, move_dir=0001. Tie case: player (363,270) → horizontal 0001.
- Attack/cooldown: player (263,90) (dist=80) → at the decision tick fire=1 for 1 cycle and ai_state=4, then 5. No move_dir for 30 frame_ticks, then ai_state=1.
- Retreat: player (270,160) (dh=7, dv=10) → ai_state=3, move_dir=0100. Player == ranger → 1000.
- Enable drop: enable=0 on the cycle of a decision tick → no pulse emitted; ai_state=0 the next cycle.
